// File: rtl/cache_pkg.sv
// Shared parameters, FSM state type and address-field helpers for the
// direct-mapped, read-only instruction/data cache controller.
package cache_pkg;

    localparam int INDEX_W     = 6;
    localparam int TAG_W       = 32 - INDEX_W - 4;
    localparam int CACHE_LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_REFILL,
        ST_RESP
    } state_e;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [31:2] addr);
        return addr[31:INDEX_W+4];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [31:2] addr);
        return addr[INDEX_W+3:4];
    endfunction

    function automatic logic [1:0] addr_word(input logic [31:2] addr);
        return addr[3:2];
    endfunction

endpackage

// File: rtl/cache_ctrl_refill_seq.sv
// Refill beat counter plus capture of the requested word while the line
// streams in from memory.
module refill_seq
    import cache_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        beat_en_i,
    input  logic [1:0]  word_i,
    input  logic [31:0] mem_rdata_i,
    output logic [1:0]  beat_o,
    output logic        last_o,
    output logic [31:0] rdata_o
);

    logic [1:0]  beat_q, beat_d;
    logic [31:0] rdata_q, rdata_d;

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        beat_d  = beat_q;
        rdata_d = rdata_q;
        if (start_i) begin
            beat_d = '0;
        end else if (beat_en_i) begin
            beat_d = beat_q + 2'd1;
            if (beat_q == word_i) begin
                rdata_d = mem_rdata_i;
            end
        end
    end

    // NOTE: sequential state uses <= so all flops update from pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beat_q  <= '0;
            rdata_q <= '0;
        end else begin
            beat_q  <= beat_d;
            rdata_q <= rdata_d;
        end
    end

    assign beat_o  = beat_q;
    assign last_o  = beat_en_i && (beat_q == 2'd3);
    assign rdata_o = rdata_q;

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped read-only cache controller: 4-word lines, external tag/data
// RAMs (registered read on posedge, write on negedge), valid bits in flops.
module cache_ctrl
    import cache_pkg::*;
(
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   CpuReq,
    input  logic [31:0]            CpuAddr,
    input  logic                   Invalidate,
    output logic                   CpuReady,
    output logic [31:0]            CpuRData,
    output logic                   MemReq,
    output logic [31:0]            MemAddr,
    input  logic                   MemReady,
    input  logic [31:0]            MemRData,
    output logic [INDEX_W-1:0]     TagAddr,
    output logic [TAG_W-1:0]       TagIn,
    output logic                   TagWrite,
    input  logic [TAG_W-1:0]       TagOut,
    output logic [INDEX_W+1:0]     DataAddr,
    output logic [31:0]            DataIn,
    output logic                   DataWrite,
    input  logic [31:0]            DataOut
);

    state_e                  state_q, state_d;
    logic [31:2]             req_addr_q, req_addr_d;
    logic [CACHE_LINES-1:0]  valid_q, valid_d;

    logic [TAG_W-1:0]        req_tag;
    logic [INDEX_W-1:0]      req_index;
    logic [1:0]              req_word;
    logic                    hit;
    logic                    refill_start;
    logic                    beat_en;
    logic [1:0]              beat;
    logic                    last_beat;
    logic [31:0]             resp_data;

    assign req_tag      = addr_tag(req_addr_q);
    assign req_index    = addr_index(req_addr_q);
    assign req_word     = addr_word(req_addr_q);
    assign hit          = valid_q[req_index] && (TagOut == req_tag);
    assign refill_start = (state_q == ST_LOOKUP) && !hit;
    assign beat_en      = (state_q == ST_REFILL) && MemReady;

    refill_seq u_refill_seq (
        .clk_i       (Clk),
        .rst_i       (Rst),
        .start_i     (refill_start),
        .beat_en_i   (beat_en),
        .word_i      (req_word),
        .mem_rdata_i (MemRData),
        .beat_o      (beat),
        .last_o      (last_beat),
        .rdata_o     (resp_data)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: valid bits are plain flops, not RAM, so they can and must be cleared by reset.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            req_addr_q <= '0;
            valid_q    <= '0;
        end else begin
            req_addr_q <= req_addr_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        valid_d    = valid_q;
        TagAddr    = addr_index(CpuAddr[31:2]);
        TagIn      = req_tag;
        TagWrite   = 1'b0;
        DataAddr   = {addr_index(CpuAddr[31:2]), addr_word(CpuAddr[31:2])};
        DataIn     = MemRData;
        DataWrite  = 1'b0;
        CpuReady   = 1'b0;
        CpuRData   = '0;
        MemReq     = 1'b0;
        MemAddr    = '0;

        unique case (state_q)
            ST_IDLE: begin
                // Invalidate wins; a held CpuReq is simply accepted a cycle later.
                if (Invalidate) begin
                    valid_d = '0;
                end else if (CpuReq) begin
                    req_addr_d = CpuAddr[31:2];
                    state_d    = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                TagAddr  = req_index;
                DataAddr = {req_index, req_word};
                if (hit) begin
                    CpuReady = 1'b1;
                    CpuRData = DataOut;
                    state_d  = ST_IDLE;
                end else begin
                    state_d  = ST_REFILL;
                end
            end
            ST_REFILL: begin
                MemReq   = 1'b1;
                MemAddr  = {req_tag, req_index, beat, 2'b00};
                TagAddr  = req_index;
                DataAddr = {req_index, beat};
                if (MemReady) begin
                    DataWrite = 1'b1;
                    if (last_beat) begin
                        TagWrite           = 1'b1;
                        valid_d[req_index] = 1'b1;
                        state_d            = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                TagAddr  = req_index;
                CpuReady = 1'b1;
                CpuRData = resp_data;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: behavioural tag/data RAMs and a backing
// memory whose word at address A is a fixed function of A.
module tb_cache_ctrl;
    import cache_pkg::*;

    logic                   Clk = 1'b0;
    logic                   Rst;
    logic                   CpuReq;
    logic [31:0]            CpuAddr;
    logic                   Invalidate;
    logic                   CpuReady;
    logic [31:0]            CpuRData;
    logic                   MemReq;
    logic [31:0]            MemAddr;
    logic                   MemReady;
    logic [31:0]            MemRData;
    logic [INDEX_W-1:0]     TagAddr;
    logic [TAG_W-1:0]       TagIn;
    logic                   TagWrite;
    logic [TAG_W-1:0]       TagOut;
    logic [INDEX_W+1:0]     DataAddr;
    logic [31:0]            DataIn;
    logic                   DataWrite;
    logic [31:0]            DataOut;

    int n_checks = 0;
    int n_errors = 0;

    logic [TAG_W-1:0] tag_ram  [CACHE_LINES];
    logic [31:0]      data_ram [CACHE_LINES*4];

    cache_ctrl dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .CpuReq     (CpuReq),
        .CpuAddr    (CpuAddr),
        .Invalidate (Invalidate),
        .CpuReady   (CpuReady),
        .CpuRData   (CpuRData),
        .MemReq     (MemReq),
        .MemAddr    (MemAddr),
        .MemReady   (MemReady),
        .MemRData   (MemRData),
        .TagAddr    (TagAddr),
        .TagIn      (TagIn),
        .TagWrite   (TagWrite),
        .TagOut     (TagOut),
        .DataAddr   (DataAddr),
        .DataIn     (DataIn),
        .DataWrite  (DataWrite),
        .DataOut    (DataOut)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
    endfunction

    assign MemRData = mem_word(MemAddr);

    always @(posedge Clk) begin
        TagOut  <= tag_ram[TagAddr];
        DataOut <= data_ram[DataAddr];
    end

    always @(negedge Clk) begin
        if (TagWrite)  tag_ram[TagAddr]   <= TagIn;
        if (DataWrite) data_ram[DataAddr] <= DataIn;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One CPU read. abort_after >= 0 returns right after that beat is accepted.
    task automatic read_txn(input logic [31:0] addr, input int wait_cycles,
                            input bit exp_hit, input int abort_after);
        logic [31:0] base;
        logic [31:0] word_addr;
        base      = {addr[31:4], 4'h0};
        word_addr = {addr[31:2], 2'b00};
        CpuAddr   = addr;
        CpuReq    = 1'b1;
        @(posedge Clk); #2;
        if (exp_hit) begin
            check("hit_ready",  CpuReady, 1);
            check("hit_data",   CpuRData, mem_word(word_addr));
            check("hit_memreq", MemReq,   0);
            CpuReq = 1'b0;
            @(posedge Clk); #2;
            check("hit_after_ready", CpuReady, 0);
            return;
        end
        check("lookup_ready",  CpuReady, 0);
        check("lookup_memreq", MemReq,   0);
        @(posedge Clk); #2;
        for (int b = 0; b < 4; b++) begin
            for (int w = 0; w < wait_cycles; w++) begin
                MemReady = 1'b0; #1;
                check("wait_memreq",  MemReq,    1);
                check("wait_memaddr", MemAddr,   base + 32'(b*4));
                check("wait_dwrite",  DataWrite, 0);
                check("wait_twrite",  TagWrite,  0);
                @(posedge Clk); #2;
            end
            MemReady = 1'b1; #1;
            check("beat_memreq",  MemReq,    1);
            check("beat_memaddr", MemAddr,   base + 32'(b*4));
            check("beat_dwrite",  DataWrite, 1);
            check("beat_daddr",   32'(DataAddr), {24'd0, addr[9:4], 2'(b)});
            check("beat_din",     DataIn,    mem_word(base + 32'(b*4)));
            check("beat_twrite",  TagWrite,  (b == 3) ? 32'd1 : 32'd0);
            check("beat_ready",   CpuReady,  0);
            if (b == 3) begin
                check("beat_taddr", 32'(TagAddr), 32'(addr[9:4]));
                check("beat_tin",   32'(TagIn),   32'(addr[31:10]));
            end
            @(posedge Clk); #2;
            if (b == abort_after) begin
                MemReady = 1'b0;
                return;
            end
        end
        MemReady = 1'b0;
        check("resp_ready",  CpuReady, 1);
        check("resp_data",   CpuRData, mem_word(word_addr));
        check("resp_memreq", MemReq,   0);
        CpuReq = 1'b0;
        @(posedge Clk); #2;
        check("idle_ready", CpuReady, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < CACHE_LINES; i++) tag_ram[i] = '0;
        for (int i = 0; i < CACHE_LINES*4; i++) data_ram[i] = '0;
        Rst        = 1'b1;
        CpuReq     = 1'b0;
        CpuAddr    = '0;
        Invalidate = 1'b0;
        MemReady   = 1'b0;
        repeat (2) @(posedge Clk);
        #2;
        check("rst_ready",  CpuReady,  0);
        check("rst_rdata",  CpuRData,  0);
        check("rst_memreq", MemReq,    0);
        check("rst_memaddr", MemAddr,  0);
        check("rst_twrite", TagWrite,  0);
        check("rst_dwrite", DataWrite, 0);
        Rst = 1'b0;
        @(posedge Clk); #2;

        // Cold miss, then a hit on another word of the same line.
        read_txn(32'h0000_1004, 0, 1'b0, -1);
        read_txn(32'h0000_1008, 0, 1'b1, -1);

        // Same index, different tag: the line is replaced both ways.
        read_txn(32'h0000_2008, 0, 1'b0, -1);
        read_txn(32'h0000_1000, 0, 1'b0, -1);

        // Slow memory: three idle cycles before each beat.
        read_txn(32'h0000_3004, 3, 1'b0, -1);
        read_txn(32'h0000_300C, 0, 1'b1, -1);

        // Invalidate beats a simultaneous request, which is taken next cycle and misses.
        CpuAddr    = 32'h0000_3004;
        CpuReq     = 1'b1;
        Invalidate = 1'b1;
        @(posedge Clk); #2;
        check("inv_ready",  CpuReady, 0);
        check("inv_memreq", MemReq,   0);
        Invalidate = 1'b0;
        read_txn(32'h0000_3004, 0, 1'b0, -1);

        // Reset after beat 2 of a refill abandons it; the line must refill again.
        read_txn(32'h0000_4008, 0, 1'b0, 2);
        check("pre_rst_memreq", MemReq, 1);
        MemReady = 1'b1;
        Rst      = 1'b1;
        #1;
        check("mid_rst_memreq",  MemReq,    0);
        check("mid_rst_memaddr", MemAddr,   0);
        check("mid_rst_dwrite",  DataWrite, 0);
        check("mid_rst_twrite",  TagWrite,  0);
        check("mid_rst_ready",   CpuReady,  0);
        check("mid_rst_rdata",   CpuRData,  0);
        MemReady = 1'b0;
        CpuReq   = 1'b0;
        @(posedge Clk); #2;
        Rst = 1'b0;
        @(posedge Clk); #2;
        read_txn(32'h0000_4008, 0, 1'b0, -1);
        read_txn(32'h0000_4000, 0, 1'b1, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 SHALL have ports: Clk  input  1  single clock; tag/data RAMs read on posedge, write on negedge.
REQ-002 SHALL have ports: Rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: CpuReq  input  1  read request, held until CpuReady.
REQ-004 SHALL have ports: CpuAddr  input  32  byte address, stable while CpuReq is high.
REQ-005 SHALL have ports: Invalidate  input  1  clear all valid bits.
REQ-006 SHALL have ports: CpuReady  output  1  one-cycle completion strobe.
REQ-007 SHALL have ports: CpuRData  output  32  read word, valid when CpuReady is high.
REQ-008 SHALL have ports: MemReq  output  1  refill beat request; MemAddr  output  32  beat address.
REQ-009 SHALL have ports: MemReady  input  1  beat accept; MemRData  input  32  beat data, valid with MemReady.
REQ-010 SHALL have ports: TagAddr  output  INDEX_W  tag RAM index; TagIn  output  TAG_W  write tag; TagWrite  output  1  tag write enable; TagOut  input  TAG_W  tag read data, registered by the RAM.
REQ-011 SHALL have ports: DataAddr  output  INDEX_W+2  {index, word}; DataIn  output  32  write data; DataWrite  output  1  data write enable; DataOut  input  32  data read data, registered.

Function
REQ-012 SHALL split CpuAddr into tag [31:INDEX_W+4], index [INDEX_W+3:4], word [3:2], and ignore [1:0]; direct-mapped, 4-word lines, read-only.
REQ-013 SHALL keep one valid bit per line (CACHE_LINES = 2^INDEX_W) in internal flops.
REQ-014 SHALL implement the FSM IDLE, LOOKUP, REFILL, RESP.
REQ-015 IDLE: TagAddr and DataAddr driven from CpuAddr; if CpuReq is high and Invalidate is low, go to LOOKUP, with the request address latched.
REQ-016 LOOKUP: hit = valid[index] and TagOut == tag; on a hit, CpuReady = 1 and CpuRData = DataOut in this cycle, then IDLE. Hit latency is 1 cycle after acceptance.
REQ-017 LOOKUP miss: go to REFILL with beat counter = 0.
REQ-018 REFILL: MemReq = 1, MemAddr = {tag, index, beat, 2'b00}; on each MemReady, DataWrite = 1, DataAddr = {index, beat}, DataIn = MemRData, beat increments.
REQ-019 REFILL: when beat == the requested word, MemRData SHALL be captured into the response register.
REQ-020 REFILL: on the MemReady of beat 3, TagWrite = 1, TagAddr = index, TagIn = tag, and valid[index] is set at the next posedge; then go to RESP.
REQ-021 RESP: CpuReady = 1 with the captured word for exactly one cycle, then IDLE. Miss latency is 1 + refill cycles + 1.
REQ-022 MemReq SHALL remain high between beats while MemReady is low; MemAddr changes only after an accepted beat.
REQ-023 Invalidate in IDLE SHALL clear all valid bits at the next posedge and take priority over a simultaneous CpuReq; the request is accepted on the following cycle.
REQ-024 Invalidate in any other state SHALL be ignored.
REQ-025 TagWrite and DataWrite SHALL be low outside REFILL; CpuReady SHALL never be high in IDLE or REFILL.
REQ-026 An index reused after a refill to another tag SHALL overwrite the line (no replacement choice).

Reset
REQ-027 Rst high SHALL asynchronously force: state IDLE, all valid bits 0, beat 0, CpuReady 0, CpuRData 0, MemReq 0, MemAddr 0, TagWrite 0, DataWrite 0.
REQ-028 Reset during REFILL SHALL abandon the refill; the partially written line stays invalid, and the memory side SHALL tolerate the dropped request.

Structure
REQ-029 The shared package cache_pkg SHALL hold INDEX_W (6), TAG_W (32-INDEX_W-4), CACHE_LINES, and the FSM state enum.
REQ-030 The beat counter and capture logic SHALL be a sub-module refill_seq; everything else stays in cache_ctrl.

Verification
REQ-031 After reset, read 0x0000_1004 with MemReady always high -> MemAddr 0x1000, 0x1004, 0x1008, 0x100C, TagWrite on beat 3, CpuReady in RESP with the beat-1 word.
REQ-032 Reread 0x0000_1008 -> hit: CpuReady exactly 1 cycle after acceptance, no MemReq.
REQ-033 Read 0x0000_2008 (same index, different tag) -> miss and refill; a subsequent read of 0x0000_1000 misses again.
REQ-034 MemReady low for 3 cycles per beat -> MemReq and MemAddr held stable; the returned data is still correct.
REQ-035 Invalidate together with CpuReq in IDLE -> next-cycle acceptance; a previously cached address misses.
REQ-036 Rst pulsed after beat 2 of a refill -> all outputs 0 immediately; rereading that address misses and refills all 4 beats.
